// File: rtl/spi_master_pkg.sv
// Shared constants, FSM encoding and counter-sizing helpers for the SPI master.
package spi_master_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Bits needed to hold a down-counter running from n-1 to 0 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_master_clk_gen.sv
// sclk divider: registered sclk toggling every CLK_DIV cycles while enabled, idle low.
// The strobes mark the cycle whose closing edge makes sclk rise or fall.
module spi_clk_gen
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int DW = cnt_w(CLK_DIV);

  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick     = en && (div_cnt == '0);
  assign rise_stb = tick && !sclk;
  assign fall_stb = tick && sclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk    <= 1'b0;
      div_cnt <= '0;
    end else if (!en) begin
      sclk    <= 1'b0;
      div_cnt <= '0;
    end else if (tick) begin
      sclk    <= ~sclk;
      div_cnt <= DW'(CLK_DIV - 1);
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first: one full-duplex DATA_W-bit frame per accepted start.
//   state | meaning
//   IDLE  | ss high, waiting for start
//   SETUP | ss low, sclk low, MSB on mosi for SS_SETUP cycles
//   XFER  | DATA_W sclk periods, then one trailing low phase (tail)
//   HOLD  | ss low, sclk low for SS_HOLD cycles
//   GAP   | ss high, done pulsed on entry, busy held for SS_GAP cycles
module spi_master
  import spi_master_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CLK_DIV  = 4,
  parameter int SS_SETUP = 2,
  parameter int SS_HOLD  = 2,
  parameter int SS_GAP   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int TMR_MAX = max_of(max_of(CLK_DIV, SS_SETUP), max_of(SS_HOLD, SS_GAP));
  localparam int TW      = cnt_w(TMR_MAX);
  localparam int BW      = cnt_w(DATA_W);

  state_t            state;
  logic [TW-1:0]     tmr;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              tail;
  logic              clk_en;
  logic              rise_stb;
  logic              fall_stb;

  // Divider runs from the last SETUP cycle so the first rise lands exactly SS_SETUP after ss falls.
  assign clk_en = ((state == ST_SETUP) && (tmr == '0)) || ((state == ST_XFER) && !tail);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (clk_en),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tmr      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tail     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      ss       <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SETUP;
            busy    <= 1'b1;
            ss      <= 1'b0;
            shreg   <= data_in;
            mosi    <= data_in[DATA_W-1];
            tmr     <= TW'(SS_SETUP - 1);
            bit_cnt <= '0;
            tail    <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (rise_stb) state <= ST_XFER;
          else          tmr   <= tmr - 1'b1;
        end
        ST_XFER: begin
          if (tail) begin
            if (tmr == '0) begin
              state <= ST_HOLD;
              tmr   <= TW'(SS_HOLD - 1);
            end else begin
              tmr <= tmr - 1'b1;
            end
          end else if (fall_stb) begin
            // Sample at the end of the high phase; mosi moves to the next bit on the same edge.
            shreg <= {shreg[DATA_W-2:0], miso};
            if (bit_cnt == BW'(DATA_W - 1)) begin
              tail <= 1'b1;
              tmr  <= TW'(CLK_DIV - 1);
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              mosi    <= shreg[DATA_W-2];
            end
          end
        end
        ST_HOLD: begin
          if (tmr == '0) begin
            state    <= ST_GAP;
            ss       <= 1'b1;
            data_out <= shreg;
            done     <= 1'b1;
            tmr      <= TW'(SS_GAP - 1);
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_GAP: begin
          if (tmr == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
